// File: rtl/mole_hit_scorer.sv
// Whack-a-mole hit detector and packed-BCD scorer: LED drive, button edge detect, two-stage score pipe.
// Optional build macro MISS_PENALTY_EN: a press on an unlit LED costs one point (score floors at 0).
module mole_hit_scorer #(
    parameter int N_MOLES  = 4,
    parameter int N_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_MOLES-1:0]      button,
    input  logic [1:0]              state,
    input  logic                    lct,
    input  logic [N_MOLES-1:0]      q,
    output logic [N_MOLES-1:0]      color,
    output logic [4*N_DIGITS-1:0]   score,
    output logic                    hit,
    output logic                    sat
);

    localparam int SW = 4 * N_DIGITS;
    // One spare digit catches the overflow of score + hits before saturation is applied
    localparam int EW = SW + 4;
    localparam logic [SW-1:0] ALL_NINES = {N_DIGITS{4'h9}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_END   = 2'b10,
        ST_PAUSE = 2'b11
    } game_state_e;

    function automatic logic [3:0] popcount(input logic [N_MOLES-1:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < N_MOLES; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

    // Adds a single-digit amount to a BCD word, rippling the carry through every digit
    function automatic logic [EW-1:0] bcd_add(input logic [EW-1:0] a, input logic [3:0] b);
        logic [EW-1:0] r;
        logic [4:0]    d;
        logic [3:0]    c;
        r = '0;
        c = b;
        for (int i = 0; i < N_DIGITS + 1; i++) begin
            d = {1'b0, a[4*i+:4]} + {1'b0, c};
            if (d > 5'd9) begin
                r[4*i+:4] = 4'(d - 5'd10);
                c = 4'd1;
            end else begin
                r[4*i+:4] = d[3:0];
                c = 4'd0;
            end
        end
        return r;
    endfunction

`ifdef MISS_PENALTY_EN
    // Subtracts a single-digit amount; MSB of the result flags a borrow out of the top digit
    function automatic logic [EW:0] bcd_sub(input logic [EW-1:0] a, input logic [3:0] b);
        logic [EW-1:0] r;
        logic [3:0]    c;
        r = '0;
        c = b;
        for (int i = 0; i < N_DIGITS + 1; i++) begin
            if (a[4*i+:4] >= c) begin
                r[4*i+:4] = a[4*i+:4] - c;
                c = 4'd0;
            end else begin
                r[4*i+:4] = a[4*i+:4] + 4'd10 - c;
                c = 4'd1;
            end
        end
        return {(c != 4'd0), r};
    endfunction
`endif

    game_state_e          state_s;
    logic [N_MOLES-1:0]   btn_q_r;
    logic [N_MOLES-1:0]   rise_s;
    logic [N_MOLES-1:0]   hit_mask_s;
    logic [N_MOLES-1:0]   hit_mask_r;
    logic [3:0]           nh_r;
    logic [N_MOLES-1:0]   color_r;
    logic [N_MOLES-1:0]   color_nxt_s;
    logic [SW-1:0]        score_r;
    logic [SW-1:0]        score_nxt_s;
    logic                 hit_r;
    logic                 hit_nxt_s;
    logic                 sat_r;
    logic                 sat_nxt_s;
    logic [EW-1:0]        sum_ext_s;
    logic [EW-1:0]        res_ext_s;
    logic                 ovf_s;
`ifdef MISS_PENALTY_EN
    logic [N_MOLES-1:0]   miss_mask_s;
    logic [N_MOLES-1:0]   miss_mask_r;
    logic [3:0]           nm_r;
    logic [EW:0]          sub_s;
`endif

    assign state_s = game_state_e'(state);
    assign color   = color_r;
    assign score   = score_r;
    assign hit     = hit_r;
    assign sat     = sat_r;

    // Button history, tracked in every state so a press held across a pause never scores twice
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_q_r <= '0;
        end else begin
            btn_q_r <= button;
        end
    end

    // Stage 1: classify new presses against the LEDs as they were before this edge
    always_comb begin
        rise_s     = button & ~btn_q_r;
        hit_mask_s = '0;
`ifdef MISS_PENALTY_EN
        miss_mask_s = '0;
`endif
        if (state_s == ST_RUN) begin
            hit_mask_s = rise_s & color_r;
`ifdef MISS_PENALTY_EN
            miss_mask_s = rise_s & ~color_r;
`endif
        end else begin
            hit_mask_s = '0;
        end
    end

    // LED next value; a reload tick wins over clearing a hit mole
    always_comb begin
        color_nxt_s = '0;
        case (state_s)
            ST_RUN: begin
                if (lct) begin
                    color_nxt_s = q;
                end else begin
                    color_nxt_s = color_r & ~hit_mask_s;
                end
            end
            ST_PAUSE: color_nxt_s = color_r;
            ST_IDLE:  color_nxt_s = '0;
            ST_END:   color_nxt_s = '0;
            default:  color_nxt_s = '0;
        endcase
    end

    // LED register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            color_r <= '0;
        end else begin
            color_r <= color_nxt_s;
        end
    end

    // Stage-2 registers; outside RUN they load zero so the pipe drains and stays empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_mask_r <= '0;
            nh_r       <= 4'd0;
`ifdef MISS_PENALTY_EN
            miss_mask_r <= '0;
            nm_r        <= 4'd0;
`endif
        end else if (state_s == ST_RUN) begin
            hit_mask_r <= hit_mask_s;
            nh_r       <= popcount(hit_mask_s);
`ifdef MISS_PENALTY_EN
            miss_mask_r <= miss_mask_s;
            nm_r        <= popcount(miss_mask_s);
`endif
        end else begin
            hit_mask_r <= '0;
            nh_r       <= 4'd0;
`ifdef MISS_PENALTY_EN
            miss_mask_r <= '0;
            nm_r        <= 4'd0;
`endif
        end
    end

    // Stage 2: score arithmetic with saturation at all nines (and floor at zero under penalty)
    always_comb begin
        sum_ext_s = bcd_add({4'd0, score_r}, nh_r);
`ifdef MISS_PENALTY_EN
        sub_s = bcd_sub(sum_ext_s, nm_r);
        if (sub_s[EW] || (miss_mask_r == '1 && 1'b0)) begin
            res_ext_s = '0;
        end else begin
            res_ext_s = sub_s[EW-1:0];
        end
`else
        res_ext_s = sum_ext_s;
`endif
        ovf_s = (res_ext_s[EW-1:SW] != 4'd0);
    end

    // Score, hit pulse and sticky saturation next values
    always_comb begin
        score_nxt_s = score_r;
        hit_nxt_s   = 1'b0;
        sat_nxt_s   = sat_r;
        case (state_s)
            ST_IDLE: begin
                score_nxt_s = '0;
                hit_nxt_s   = 1'b0;
                sat_nxt_s   = 1'b0;
            end
            ST_RUN, ST_END, ST_PAUSE: begin
                if (ovf_s) begin
                    score_nxt_s = ALL_NINES;
                end else begin
                    score_nxt_s = res_ext_s[SW-1:0];
                end
                hit_nxt_s = (hit_mask_r != '0);
                sat_nxt_s = sat_r | ovf_s;
            end
            default: begin
                score_nxt_s = '0;
                hit_nxt_s   = 1'b0;
                sat_nxt_s   = 1'b0;
            end
        endcase
    end

    // Score output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            score_r <= '0;
            hit_r   <= 1'b0;
            sat_r   <= 1'b0;
        end else begin
            score_r <= score_nxt_s;
            hit_r   <= hit_nxt_s;
            sat_r   <= sat_nxt_s;
        end
    end

endmodule

// File: tb/tb_mole_hit_scorer.sv
// Self-checking bench for mole_hit_scorer: directed scenarios plus random play against an integer score model.
module tb_mole_hit_scorer;

    localparam int MAXV = 9999;
    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_END   = 2'b10;
    localparam logic [1:0] S_PAUSE = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  button;
    logic [1:0]  state;
    logic        lct;
    logic [3:0]  q;
    logic [3:0]  color;
    logic [15:0] score;
    logic        hit;
    logic        sat;

    int errors = 0;
    int checks = 0;

    // Behavioural model: integer score, lit-mole set, last button levels, counts awaiting scoring
    int       m_score;
    bit       m_sat;
    bit       m_hit;
    bit [3:0] m_color;
    bit [3:0] m_prev;
    int       m_pnh;
    int       m_pnm;

    always #5 clk = ~clk;

    mole_hit_scorer #(.N_MOLES(4), .N_DIGITS(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .button (button),
        .state  (state),
        .lct    (lct),
        .q      (q),
        .color  (color),
        .score  (score),
        .hit    (hit),
        .sat    (sat)
    );

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int t;
        t = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i+:4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, update the model from the pre-edge inputs, then compare all outputs
    task automatic cycle();
        bit [3:0] rise;
        bit [3:0] n_color;
        int       v;
        int       n_score;
        bit       n_sat;
        bit       n_hit;
        int       n_pnh;
        int       n_pnm;
        rise = button & ~m_prev;
        if (state == S_IDLE) begin
            n_score = 0;
            n_sat   = 1'b0;
            n_hit   = 1'b0;
        end else begin
            v = m_score + m_pnh;
`ifdef MISS_PENALTY_EN
            v = v - m_pnm;
`endif
            if (v < 0) v = 0;
            n_sat = m_sat;
            if (v > MAXV) begin
                v     = MAXV;
                n_sat = 1'b1;
            end
            n_score = v;
            n_hit   = (m_pnh > 0);
        end
        if (state == S_RUN) begin
            n_pnh = $countones(rise & m_color);
            n_pnm = $countones(rise & ~m_color);
        end else begin
            n_pnh = 0;
            n_pnm = 0;
        end
        case (state)
            S_RUN:   n_color = lct ? q : (m_color & ~(rise & m_color));
            S_PAUSE: n_color = m_color;
            default: n_color = 4'b0000;
        endcase
        @(posedge clk);
        #1;
        if (rst) begin
            m_score = 0; m_sat = 1'b0; m_hit = 1'b0; m_color = 4'b0000;
            m_prev = 4'b0000; m_pnh = 0; m_pnm = 0;
        end else begin
            m_score = n_score; m_sat = n_sat; m_hit = n_hit; m_color = n_color;
            m_prev = button; m_pnh = n_pnh; m_pnm = n_pnm;
        end
        chk("color", 32'(color), 32'(m_color));
        chk("score", 32'(score), 32'(to_bcd(m_score)));
        chk("hit", 32'(hit), 32'(m_hit));
        chk("sat", 32'(sat), 32'(m_sat));
    endtask

    // Light every LED, press the buttons in mask, release; the score settles on the last edge
    task automatic round(input logic [3:0] mask);
        state = S_RUN; lct = 1'b1; q = 4'b1111; button = 4'b0000;
        cycle();
        lct = 1'b0; button = mask;
        cycle();
        button = 4'b0000;
        cycle();
    endtask

    task automatic reach(input int target);
        int k;
        while (m_score < target) begin
            k = target - m_score;
            if (k >= 4) round(4'b1111);
            else if (k == 3) round(4'b0111);
            else if (k == 2) round(4'b0011);
            else round(4'b0001);
        end
    endtask

    initial begin
        int s0;
        m_score = 0; m_sat = 1'b0; m_hit = 1'b0; m_color = 4'b0000;
        m_prev = 4'b0000; m_pnh = 0; m_pnm = 0;
        rst = 1'b1; button = 4'b0000; state = S_IDLE; lct = 1'b0; q = 4'b0000;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();

        // Asynchronous reset in the middle of a game
        reach(42);
        chk("pre_reset_score", 32'(score), 32'h0042);
        state = S_RUN; lct = 1'b1; q = 4'b0110;
        cycle();
        lct = 1'b0;
        rst = 1'b1;
        #1;
        chk("async_color", 32'(color), 32'h0);
        chk("async_score", 32'(score), 32'h0);
        chk("async_hit", 32'(hit), 32'h0);
        chk("async_sat", 32'(sat), 32'h0);
        cycle();
        rst = 1'b0;
        state = S_RUN;
        cycle();
        chk("no_led_before_lct", 32'(color), 32'h0);

        // Two simultaneous hits
        s0 = m_score;
        lct = 1'b1; q = 4'b1011;
        cycle();
        lct = 1'b0;
        cycle();
        button = 4'b1001;
        cycle();
        chk("two_hit_color", 32'(color), 32'h2);
        cycle();
        chk("two_hit_score", 32'(score), 32'(to_bcd(s0 + 2)));
        chk("two_hit_pulse", 32'(hit), 32'h1);
        cycle();
        chk("two_hit_pulse_end", 32'(hit), 32'h0);
        button = 4'b0000;
        cycle();

        // Multi-digit carry, saturation, clear in IDLE
        reach(99);
        round(4'b0001);
        chk("carry_0100", 32'(score), 32'h0100);
        reach(MAXV);
        chk("at_max_sat", 32'(sat), 32'h0);
        round(4'b0001);
        chk("sat_score", 32'(score), 32'h9999);
        chk("sat_flag", 32'(sat), 32'h1);
        state = S_IDLE;
        cycle();
        chk("idle_score", 32'(score), 32'h0);
        chk("idle_sat", 32'(sat), 32'h0);

        // Held button across a pause scores once
        s0 = m_score;
        state = S_RUN; lct = 1'b1; q = 4'b0010;
        cycle();
        lct = 1'b0; button = 4'b0010;
        for (int i = 0; i < 20; i++) cycle();
        state = S_PAUSE;
        for (int i = 0; i < 3; i++) cycle();
        state = S_RUN; lct = 1'b1; q = 4'b0010;
        cycle();
        lct = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        chk("held_once", 32'(score), 32'(to_bcd(s0 + 1)));
        button = 4'b0000;
        cycle();

        // Reload and press on the same edge: hit counts, reload wins
        s0 = m_score;
        lct = 1'b1; q = 4'b0100;
        cycle();
        lct = 1'b1; q = 4'b0100; button = 4'b0100;
        cycle();
        chk("reload_wins", 32'(color[2]), 32'h1);
        lct = 1'b0;
        cycle();
        chk("reload_hit_scored", 32'(score), 32'(to_bcd(s0 + 1)));
        button = 4'b0000;
        cycle();

        // Three misses in one cycle with score 1
        state = S_IDLE;
        cycle();
        reach(1);
        state = S_RUN; lct = 1'b1; q = 4'b0001; button = 4'b0000;
        cycle();
        lct = 1'b0; button = 4'b1110;
        cycle();
        button = 4'b0000;
        cycle();
        chk("miss_hit", 32'(hit), 32'h0);
`ifdef MISS_PENALTY_EN
        chk("miss_score", 32'(score), 32'h0000);
`else
        chk("miss_score", 32'(score), 32'h0001);
`endif

        // Hit on the last RUN cycle still scores after END
        s0 = m_score;
        lct = 1'b1; q = 4'b1000;
        cycle();
        lct = 1'b0; button = 4'b1000;
        cycle();
        state = S_END; button = 4'b0000;
        cycle();
        chk("end_drain", 32'(score), 32'(to_bcd(s0 + 1)));
        chk("end_color", 32'(color), 32'h0);

        // Random play
        for (int i = 0; i < 600; i++) begin
            int r;
            r = int'($urandom_range(0, 31));
            if (r == 0) state = S_IDLE;
            else if (r == 1) state = S_END;
            else if (r == 2) state = S_PAUSE;
            else state = S_RUN;
            lct = ($urandom_range(0, 3) == 0);
            q = 4'($urandom);
            button = 4'($urandom);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
